// File: rtl/muldiv_seq_if.sv
// Issue/result bundle between the execute stage, the HI/LO multiply/divide
// sequencer and the hazard unit.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic [1:0]       op_kind;
  logic             unsigned_instr;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             flush;
  logic             hilo_dep_d;
  logic             busy;
  logic             stall_req;
  logic             done;
  logic             hilo_write;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             div_by_zero;

  modport master (
    output op_valid, op_kind, unsigned_instr, op1, op2, flush, hilo_dep_d,
    input  busy, stall_req, done, hilo_write, hi_out, lo_out, div_by_zero
  );

  modport slave (
    input  op_valid, op_kind, unsigned_instr, op1, op2, flush, hilo_dep_d,
    output busy, stall_req, done, hilo_write, hi_out, lo_out, div_by_zero
  );
endinterface

// File: rtl/muldiv_seq.sv
// HI/LO multiply/divide sequencer: fixed-latency multiply, radix-2 restoring
// divide, result presented on a one-cycle done/hilo_write pulse.
module muldiv_seq #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  muldiv_seq_if.slave bus
);
  localparam int CNT_MAX = (WIDTH > MULT_LAT) ? WIDTH : MULT_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;       // product, or {rem, quot} while dividing
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;

  logic               s1, s2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [2*WIDTH-1:0] op1_ext, op2_ext, product;
  logic [WIDTH:0]     rem_sh, trial;
  logic               is_mul, is_div, accept, done_w;

  assign is_mul = (bus.op_kind == 2'b01);
  assign is_div = (bus.op_kind == 2'b10);
  assign accept = bus.op_valid & ~bus.flush & (is_mul | is_div);

  assign s1   = ~bus.unsigned_instr & bus.op1[WIDTH-1];
  assign s2   = ~bus.unsigned_instr & bus.op2[WIDTH-1];
  assign mag1 = s1 ? -bus.op1 : bus.op1;
  assign mag2 = s2 ? -bus.op2 : bus.op2;

  // Extending each operand to 2W with its sign lets one plain 2W multiply
  // serve both MULT and MULTU; only the low 2W bits are kept.
  assign op1_ext = {{WIDTH{s1}}, bus.op1};
  assign op2_ext = {{WIDTH{s2}}, bus.op2};
  assign product = op1_ext * op2_ext;

  // The shifted remainder needs W+1 bits; bit W of the trial difference is the borrow.
  assign rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
  assign trial  = rem_sh - {1'b0, divisor_q};

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    divisor_d = divisor_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mul) begin
            acc_d   = product;
            cnt_d   = CNT_W'(MULT_LAT);
            state_d = S_MUL;
          end else if (bus.op2 == '0) begin
            hi_d    = bus.op1;
            lo_d    = '1;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            acc_d     = {{WIDTH{1'b0}}, mag1};
            divisor_d = mag2;
            qneg_d    = s1 ^ s2;
            rneg_d    = s1;
            cnt_d     = CNT_W'(WIDTH);
            state_d   = S_DIV;
          end
        end
      end
      S_MUL: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = acc_q[2*WIDTH-1:WIDTH];
          lo_d    = acc_q[WIDTH-1:0];
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (!trial[WIDTH]) acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else               acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        lo_d    = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        hi_d    = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        dbz_d   = 1'b0;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // An abort wins over everything, including a result about to be published.
    if (bus.flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      divisor_q <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      divisor_q <= divisor_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
    end
  end

  assign done_w          = (state_q == S_DONE) & ~bus.flush;
  assign bus.done        = done_w;
  assign bus.hilo_write  = done_w;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.stall_req   = bus.hilo_dep_d & (state_q != S_IDLE);
  assign bus.hi_out      = hi_q;
  assign bus.lo_out      = lo_q;
  assign bus.div_by_zero = dbz_q;
endmodule
